// File: rtl/mul_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
//   - default operand width and WAIT timeout
//   - wait-counter width (covers the full legal TIMEOUT range 2..255)
//   - FSM state enumeration
//   - helper to turn a requester index into a two-bit one-hot pulse vector
package mul_pkg;

   localparam int unsigned DW_DEF      = 16;
   localparam int unsigned TIMEOUT_DEF = 64;
   localparam int unsigned CNT_W       = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } state_e;

   // Requester index -> per-requester pulse vector {req1, req0}
   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst  : clock, synchronous active-high reset
//   req[1:0]  : request vector
//   advance   : commit the current grant as the new "last granted"
//   grant[1:0]: one-hot grant (combinational), zero when nothing is requested
// A lone request is granted directly; on a tie the requester that was not
// granted last time wins. After reset requester 1 counts as last granted.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_q;
   logic last_d;

   // Grant selection
   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Pointer update only when a grant is actually taken
   always_comb begin
      last_d = last_q;
      if (advance && (grant != 2'b00)) begin
         last_d = grant[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates two requesters onto one shared sequential multiplier.
// A granted request's operands are captured, streamed to the multiplier as
// A then B under mul_start, and the result is returned with a done pulse, or
// the request is aborted with an err pulse if the multiplier does not finish
// within TIMEOUT WAIT cycles.
//   clk, rst          : clock, synchronous active-high reset
//   req_N, a_N, b_N   : requester N request and operands (N = 0, 1)
//   done_N, err_N     : one-cycle completion / timeout pulses for requester N
//   product           : result of the last completed operation
//   busy              : high whenever the FSM is not in IDLE
//   mul_start/mul_data: operand stream to the multiplier
//   mul_done/mul_product: multiplier completion and result
// All outputs are registered and aligned with the state they belong to.
module mul_arbiter
   import mul_pkg::*;
#(
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_0,
   input  logic            req_1,
   input  logic [DW-1:0]   a_0,
   input  logic [DW-1:0]   b_0,
   input  logic [DW-1:0]   a_1,
   input  logic [DW-1:0]   b_1,
   output logic            done_0,
   output logic            done_1,
   output logic            err_0,
   output logic            err_1,
   output logic [2*DW-1:0] product,
   output logic            busy,
   output logic            mul_start,
   output logic [DW-1:0]   mul_data,
   input  logic            mul_done,
   input  logic [2*DW-1:0] mul_product
);

   localparam int unsigned PW = 2 * DW;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e          state_q,     state_d;
   logic            gnt_q,       gnt_d;
   logic [DW-1:0]   a_q,         a_d;
   logic [DW-1:0]   b_q,         b_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [PW-1:0]   product_q,   product_d;
   logic [1:0]      done_q,      done_d;
   logic [1:0]      err_q,       err_d;
   logic            busy_q,      busy_d;
   logic            mul_start_q, mul_start_d;
   logic [DW-1:0]   mul_data_q,  mul_data_d;

   logic [1:0]      grant;
   logic            advance;

   // Arbitration is only consulted, and its pointer only moves, in IDLE
   assign advance = (state_q == IDLE) && (req_0 || req_1);

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .rst     (rst),
      .req     ({req_1, req_0}),
      .advance (advance),
      .grant   (grant)
   );

   // Next state and next registered outputs
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      a_d         = a_q;
      b_d         = b_q;
      cnt_d       = '0;
      product_d   = product_q;
      done_d      = 2'b00;
      err_d       = 2'b00;
      busy_d      = 1'b0;
      mul_start_d = 1'b0;
      mul_data_d  = '0;

      unique case (state_q)
         IDLE: begin
            unique case (grant)
               2'b01: begin
                  gnt_d   = 1'b0;
                  a_d     = a_0;
                  b_d     = b_0;
                  state_d = LOAD_A;
               end
               2'b10: begin
                  gnt_d   = 1'b1;
                  a_d     = a_1;
                  b_d     = b_1;
                  state_d = LOAD_A;
               end
               default: state_d = IDLE;
            endcase
         end
         LOAD_A: state_d = LOAD_B;
         LOAD_B: state_d = WAIT;
         WAIT: begin
            // Completion is tested first so it wins over a coincident timeout
            if (mul_done) begin
               product_d = mul_product;
               state_d   = RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = onehot2(gnt_q);
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs registered from the state being entered so they line up with it
      busy_d      = (state_d != IDLE);
      mul_start_d = (state_d == LOAD_A) || (state_d == LOAD_B);
      if (state_d == LOAD_A) begin
         mul_data_d = a_d;
      end else if (state_d == LOAD_B) begin
         mul_data_d = b_d;
      end
      if (state_d == RESP) begin
         done_d = onehot2(gnt_d);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         product_q   <= '0;
         done_q      <= 2'b00;
         err_q       <= 2'b00;
         busy_q      <= 1'b0;
         mul_start_q <= 1'b0;
         mul_data_q  <= '0;
      end else begin
         gnt_q       <= gnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         product_q   <= product_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         mul_start_q <= mul_start_d;
         mul_data_q  <= mul_data_d;
      end
   end

   assign done_0    = done_q[0];
   assign done_1    = done_q[1];
   assign err_0     = err_q[0];
   assign err_1     = err_q[1];
   assign product   = product_q;
   assign busy      = busy_q;
   assign mul_start = mul_start_q;
   assign mul_data  = mul_data_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter. Inputs are driven and outputs sampled
// on the falling clock edge; the expected behaviour comes from a transaction
// level model (round-robin winner, a*b product, cycle at which each pulse is due).
module tb_mul_arbiter;

   localparam int unsigned DW = 16;
   localparam int unsigned PW = 2 * DW;
   localparam int unsigned TO = 12;

   logic          clk;
   logic          rst;
   logic          req_0, req_1;
   logic [DW-1:0] a_0, b_0, a_1, b_1;
   logic          done_0, done_1, err_0, err_1;
   logic [PW-1:0] product;
   logic          busy;
   logic          mul_start;
   logic [DW-1:0] mul_data;
   logic          mul_done;
   logic [PW-1:0] mul_product;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int            last_m = 1;
   logic [PW-1:0] prod_m = '0;

   mul_arbiter #(.DW(DW), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_0       (req_0),
      .req_1       (req_1),
      .a_0         (a_0),
      .b_0         (b_0),
      .a_1         (a_1),
      .b_1         (b_1),
      .done_0      (done_0),
      .done_1      (done_1),
      .err_0       (err_0),
      .err_1       (err_1),
      .product     (product),
      .busy        (busy),
      .mul_start   (mul_start),
      .mul_data    (mul_data),
      .mul_done    (mul_done),
      .mul_product (mul_product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, 64'({done_1, done_0, err_1, err_0, busy, mul_start, mul_data, product}), 64'(0));
   endtask

   task automatic do_reset();
      rst = 1'b1; req_0 = 1'b0; req_1 = 1'b0; mul_done = 1'b0;
      step();
      step();
      chk_all_zero("reset_outputs");
      rst = 1'b0;
      last_m = 1;
      prod_m = '0;
   endtask

   // One transaction starting from an IDLE cycle. k = WAIT cycle index in which
   // mul_done is presented (k < 0: never). junk = mul_done held high in IDLE/LOAD_A.
   task automatic do_op(input logic r0, input logic r1,
                        input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                        input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                        input int k, input bit junk);
      int            w;
      int            n;
      logic [DW-1:0] ea, eb;
      logic [PW-1:0] ep;
      if (r0 && r1) w = (last_m == 1) ? 0 : 1;
      else          w = r1 ? 1 : 0;
      last_m = w;
      ea = (w == 1) ? a1 : a0;
      eb = (w == 1) ? b1 : b0;
      ep = PW'(ea) * PW'(eb);

      chk("idle_busy",  64'(busy), 64'(0));
      chk("idle_start", 64'(mul_start), 64'(0));
      chk("idle_prod",  64'(product), 64'(prod_m));
      req_0 = r0; req_1 = r1; a_0 = a0; b_0 = b0; a_1 = a1; b_1 = b1;
      mul_done = junk; mul_product = PW'($urandom);
      step();

      chk("loada_start", 64'(mul_start), 64'(1));
      chk("loada_data",  64'(mul_data), 64'(ea));
      chk("loada_busy",  64'(busy), 64'(1));
      // Operands of a non-requesting side may change freely
      if (!r0) begin a_0 = DW'($urandom); b_0 = DW'($urandom); end
      if (!r1) begin a_1 = DW'($urandom); b_1 = DW'($urandom); end
      mul_done = junk; mul_product = PW'($urandom);
      step();

      chk("loadb_start", 64'(mul_start), 64'(1));
      chk("loadb_data",  64'(mul_data), 64'(eb));
      mul_done = 1'b0;
      step();

      n = (k < 0) ? int'(TO) : k + 1;
      for (int i = 0; i < n; i++) begin
         chk("wait_start", 64'(mul_start), 64'(0));
         chk("wait_data",  64'(mul_data), 64'(0));
         chk("wait_busy",  64'(busy), 64'(1));
         chk("wait_flags", 64'({done_1, done_0, err_1, err_0}), 64'(0));
         if (i == k) begin mul_done = 1'b1; mul_product = ep; end
         else        begin mul_done = 1'b0; mul_product = PW'($urandom); end
         step();
      end
      mul_done = 1'b0;

      if (k >= 0) begin
         chk("resp_done", 64'({done_1, done_0}), 64'((w == 1) ? 2'b10 : 2'b01));
         chk("resp_err",  64'({err_1, err_0}), 64'(0));
         chk("resp_prod", 64'(product), 64'(ep));
         chk("resp_busy", 64'(busy), 64'(1));
         prod_m = ep;
      end else begin
         chk("to_err",  64'({err_1, err_0}), 64'((w == 1) ? 2'b10 : 2'b01));
         chk("to_done", 64'({done_1, done_0}), 64'(0));
         chk("to_prod", 64'(product), 64'(prod_m));
         chk("to_busy", 64'(busy), 64'(0));
      end
      if (w == 1) req_1 = 1'b0; else req_0 = 1'b0;
      step();

      chk("post_flags", 64'({done_1, done_0, err_1, err_0}), 64'(0));
      chk("post_busy",  64'(busy), 64'(0));
   endtask

   initial begin
      rst = 1'b1; req_0 = 1'b0; req_1 = 1'b0;
      a_0 = '0; b_0 = '0; a_1 = '0; b_1 = '0;
      mul_done = 1'b0; mul_product = '0;
      @(negedge clk);
      do_reset();

      // Single request 15 x 5, result two cycles after LOAD_B
      do_op(1'b1, 1'b0, 16'd15, 16'd5, 16'd0, 16'd0, 1, 1'b0);
      chk("single_product", 64'(product), 64'd75);

      // Tie right after reset: requester 0 first, then requester 1
      do_reset();
      do_op(1'b1, 1'b1, 16'd3, 16'd4, 16'd7, 16'd6, 0, 1'b0);
      chk("tie_first_product", 64'(product), 64'd12);
      do_op(1'b0, 1'b1, 16'd3, 16'd4, 16'd7, 16'd6, 2, 1'b0);
      chk("tie_second_product", 64'(product), 64'd42);

      // Continuous requests from both sides alternate grants
      for (int i = 0; i < 4; i++) begin
         do_op(1'b1, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
               int'($urandom_range(0, 3)), 1'b0);
      end

      // Random request patterns, latencies and stray mul_done
      for (int i = 0; i < 12; i++) begin
         logic [1:0] r;
         r = 2'($urandom_range(1, 3));
         do_op(r[0], r[1], DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
               int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      end

      // Stray mul_done during IDLE and LOAD_A is ignored
      do_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 0, 1'b1);
      chk("junk_product", 64'(product), 64'hFFFE0001);

      // Timeout on requester 1 leaves product untouched
      do_op(1'b0, 1'b1, 16'd0, 16'd0, 16'd100, 16'd200, -1, 1'b0);
      chk("timeout_keeps_product", 64'(product), 64'hFFFE0001);

      // Timeout boundary: completion in the last WAIT cycle still wins
      do_op(1'b1, 1'b0, 16'd9, 16'd11, 16'd0, 16'd0, int'(TO) - 1, 1'b0);

      // Reset while in WAIT, then a late mul_done
      req_0 = 1'b0; req_1 = 1'b1; a_1 = 16'd9; b_1 = 16'd9;
      step();                 // LOAD_A
      step();                 // LOAD_B
      step();                 // WAIT 0
      step();                 // WAIT 1
      chk("midop_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      step();
      chk_all_zero("midop_reset");
      rst = 1'b0; req_1 = 1'b0;
      last_m = 1; prod_m = '0;
      mul_done = 1'b1; mul_product = 32'd81;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all_zero("after_reset_idle");
      end
      mul_done = 1'b0;

      // Operation after mid-op reset: tie goes to requester 0
      do_op(1'b1, 1'b1, 16'd2, 16'd8, 16'd5, 16'd5, 0, 1'b0);
      chk("after_reset_product", 64'(product), 64'd16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
